// File: rtl/mul_div_unit_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide unit.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The multiplier result is taken MUL_LATENCY cycles after acceptance from
// latched operands. The divider is a restoring divider working on operand
// magnitudes, with the sign fix applied on the final write.
module mul_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2
) (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'((MUL_LATENCY >= 2) ? MUL_LATENCY - 2 : 0);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q, dbz_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic [WIDTH-1:0] quot_q, rem_q, dvs_q;
  logic             qneg_q, rneg_q, dz_q;

  // Full-width product; operands are extended by one bit so that a single
  // signed multiply serves both the signed and the unsigned case.
  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic sgn);
    logic signed [WIDTH:0]     xe, ye;
    logic signed [2*WIDTH+1:0] p;
    xe = {sgn & x[WIDTH-1], x};
    ye = {sgn & y[WIDTH-1], y};
    p  = (2*WIDTH+2)'(xe) * (2*WIDTH+2)'(ye);
    return p[2*WIDTH-1:0];
  endfunction

  // Magnitude of a possibly-signed operand; the most negative value maps to
  // itself, which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  // One restoring-division iteration: shift in the next dividend bit, try to
  // subtract the divisor, keep the difference only when it did not go negative.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] quot,
                                                  input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] rem_sh, diff;
    rem_sh = {rem, quot[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    if (!diff[WIDTH]) return {diff[WIDTH-1:0], quot[WIDTH-2:0], 1'b1};
    else              return {rem_sh[WIDTH-1:0], quot[WIDTH-2:0], 1'b0};
  endfunction

  logic             accept, div_sgn, mul_sgn;
  logic [WIDTH-1:0] mul_a, mul_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign accept  = (state_q == S_IDLE) && bus.start && !bus.cancel;
  assign div_sgn = (bus.op == OP_DIV);
  // In IDLE the live operands feed the multiplier so a one-cycle latency works.
  assign mul_a   = (state_q == S_IDLE) ? bus.a : a_q;
  assign mul_b   = (state_q == S_IDLE) ? bus.b : b_q;
  assign mul_sgn = (state_q == S_IDLE) ? (bus.op == OP_MULT) : sgn_q;
  assign prod    = mul_full(mul_a, mul_b, mul_sgn);
  assign q_fix   = qneg_q ? (~quot_q + 1'b1) : quot_q;
  assign r_fix   = rneg_q ? (~rem_q + 1'b1) : rem_q;

  // Control FSM and architectural HI/LO; cancel wins over completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (bus.op)
              OP_MTHI: begin hi_q <= bus.a; done_q <= 1'b1; end
              OP_MTLO: begin lo_q <= bus.a; done_q <= 1'b1; end
              OP_MULT, OP_MULTU: begin
                if (MUL_LATENCY <= 1) begin
                  {hi_q, lo_q} <= prod;
                  done_q       <= 1'b1;
                end else begin
                  state_q <= S_MUL;
                  cnt_q   <= '0;
                end
              end
              OP_DIV, OP_DIVU: begin
                state_q <= S_DIV;
                cnt_q   <= '0;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (bus.cancel) begin
            state_q <= S_IDLE;
          end else if (cnt_q == MUL_LAST) begin
            {hi_q, lo_q} <= prod;
            done_q       <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DIV: begin
          if (bus.cancel) begin
            state_q <= S_IDLE;
          end else if (cnt_q == DIV_LAST) begin
            hi_q    <= dz_q ? a_q : r_fix;
            lo_q    <= dz_q ? '1 : q_fix;
            dbz_q   <= dz_q;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Operand latch and divider datapath: conditioning on acceptance, then iterate.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= bus.a;
      b_q    <= bus.b;
      sgn_q  <= (bus.op == OP_MULT);
      quot_q <= mag(bus.a, div_sgn);
      dvs_q  <= mag(bus.b, div_sgn);
      rem_q  <= '0;
      qneg_q <= div_sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      rneg_q <= div_sgn & bus.a[WIDTH-1];
      dz_q   <= (bus.b == '0);
    end else if ((state_q == S_DIV) && (cnt_q != DIV_LAST)) begin
      {rem_q, quot_q} <= div_step(rem_q, quot_q, dvs_q);
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, for the EX stage of the MIPS core. It replaces single-cycle combinational HI/LO handling with a pipelined multiplier and an iterative restoring divider. It exposes a busy/done handshake so the hazard unit can stall, and a cancel input so exceptions can flush an in-flight operation without corrupting HI/LO.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
MUL_LATENCY, 2, multiply latency in cycles, legal range 1..4.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only while busy=0
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops
a  input  WIDTH  rs operand (dividend or multiplicand; MTHI/MTLO source)
b  input  WIDTH  rt operand (divisor or multiplier)
cancel  input  1  abort the in-flight operation
busy  output  1  operation in progress; EX must stall
done  output  1  one-cycle pulse; new HI/LO are visible in this cycle
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
div_by_zero  output  1  set with done when a DIV/DIVU completes with b=0

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, div_by_zero=0, FSM=IDLE, counters=0. Reset aborts any operation mid-flight.
- FSM states: IDLE, MUL, DIV. Only IDLE accepts start. start while busy is ignored; the operands are not queued.
- Timing: start accepted at edge T. busy=1 during cycles T+1..T+N-1. hi/lo are written at edge T+N. done=1 for exactly cycle T+N. FSM returns to IDLE at T+N, so a new start in cycle T+N is accepted.
- Latency N per op:
  - MULT/MULTU: N=MUL_LATENCY. With MUL_LATENCY=1, busy never rises.
  - DIV/DIVU: N=WIDTH+2 (1 conditioning cycle, WIDTH iterations, 1 sign-fix/write cycle).
  - MTHI/MTLO: N=1. MTHI writes hi=a only; MTLO writes lo=a only.
  - op 110/111: ignored; no done.
- Operands are latched at acceptance. Later changes to a/b have no effect.
- MULT: {hi,lo} = signed(a)*signed(b), full 2*WIDTH product. MULTU: unsigned product.
- DIVU: lo=quotient, hi=remainder.
- DIV:
  - Divide the magnitudes.
  - Quotient is negative iff a[W-1]^b[W-1]. Remainder takes the sign of a.
  - Most-negative / -1 yields lo=most-negative, hi=0 (natural wraparound, no trap).
- b=0 on DIV/DIVU: hi=a, lo=all ones, div_by_zero=1 in the done cycle. Latency is still WIDTH+2. Otherwise div_by_zero=0 with done.
- cancel:
  - While busy=1, or in cycle T+N-1: FSM goes to IDLE at the next edge. hi/lo unchanged; no done.
  - Cancel has priority over completion in the same cycle.
  - cancel and start in the same IDLE cycle: start is dropped.
  - cancel with MTHI/MTLO start: the write is dropped.
- done and div_by_zero are registered and zero in every cycle other than the done cycle.

Test Plan:
- Reset mid-divide: start DIVU a=100 b=7, assert rst at T+5 -> next cycle busy=0, hi=0, lo=0, done never pulses; a new start is then accepted normally.
- MULT with WIDTH=32, MUL_LATENCY=2: a=0xFFFFFFFE (-2), b=3 -> busy high cycle T+1 only; done at T+2 with hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 -> done exactly at T+34 with lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> done at T+34 with div_by_zero=1, hi=0x1234, lo=0xFFFFFFFF. The next DIVU 9/3 -> div_by_zero=0, lo=3, hi=0.
- Cancel: DIVU 100/7 started, cancel pulsed at T+10 -> busy=0 from T+11, hi/lo keep prior values, no done. Repeat with cancel at T+33 -> still no write.
- Handshake: MTHI a=0xA5A5A5A5 then MTLO a=0x5A5A5A5A on consecutive cycles -> done on two consecutive cycles, hi/lo updated, busy never high. A start issued during a busy DIV is ignored, and its operands never reach hi/lo.
